// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU interrupt definitions.
//   int_source_e      interrupt source numbering, bit 0 = highest priority
//   INT_VECTOR_BASE   vector of source 0
//   INT_VECTOR_STRIDE spacing between consecutive vectors
//   IF_UNUSED_BITS    constant upper bits returned when IF is read
//   vector_of()       vector address for a source index
package cpu_pkg;
  typedef enum logic [2:0] {
    IntVBlank = 3'd0,
    IntStat   = 3'd1,
    IntTimer  = 3'd2,
    IntSerial = 3'd3,
    IntJoypad = 3'd4
  } int_source_e;
  localparam logic [7:0] INT_VECTOR_BASE   = 8'h40;
  localparam logic [7:0] INT_VECTOR_STRIDE = 8'd8;
  localparam logic [2:0] IF_UNUSED_BITS    = 3'b111;
  function automatic logic [7:0] vector_of(input logic [7:0] base, input logic [7:0] stride,
                                           input logic [7:0] n);
    return base + n * stride;
  endfunction
endpackage

// File: rtl/int_priority_enc.sv
// int_priority_enc: combinational priority encoder, lowest set index wins.
//   req_i    N-bit request vector
//   valid_o  any request bit set
//   idx_o    index of the lowest set bit (0 when none)
module int_priority_enc #(
  parameter int N  = 5,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);
  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    // scan downward so the lowest set index is the last to assign
    for (int i = N - 1; i >= 0; i--)
      if (req_i[i]) idx_o = IW'(i);
  end
endmodule

// File: rtl/cpu_interrupt_ctrl.sv
// cpu_interrupt_ctrl: holds IF/IE, raises CPU interrupt requests and latches the dispatch vector.
//   clk, reset   clock; synchronous active-high reset
//   t_cycle      T-cycle phase; register commits only at phase 3
//   irq_src      peripheral requests (pulses, or levels with edge detect)
//   reg_sel_if   access targets IF (FF0F)
//   reg_sel_ie   access targets IE (FFFF)
//   reg_write    write strobe, reg_wdata write data
//   reg_rdata    IF -> {111,IF}; IE -> IE; no select -> FF
//   ime          interrupt master enable
//   int_ack      dispatch M-cycle fetching the vector
//   int_req      ime & any enabled pending interrupt
//   halt_wake    any enabled pending interrupt, regardless of ime
//   int_vector   vector latched at the last ack (00 for a cancelled dispatch)
// Build option: define INT_EDGE_DETECT_EN to treat irq_src as levels that set IF on rising edges.
module cpu_interrupt_ctrl
  import cpu_pkg::*;
#(
  parameter int         NUM_SOURCES   = 5,
  parameter logic [7:0] VECTOR_BASE   = INT_VECTOR_BASE,
  parameter logic [7:0] VECTOR_STRIDE = INT_VECTOR_STRIDE
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             t_cycle,
  input  logic [NUM_SOURCES-1:0] irq_src,
  input  logic                   reg_sel_if,
  input  logic                   reg_sel_ie,
  input  logic                   reg_write,
  input  logic [7:0]             reg_wdata,
  output logic [7:0]             reg_rdata,
  input  logic                   ime,
  input  logic                   int_ack,
  output logic                   int_req,
  output logic                   halt_wake,
  output logic [7:0]             int_vector
);
  localparam int IW = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
  logic [NUM_SOURCES-1:0] if_q, if_d, if_wr, pending, set_mask, clr_mask;
  logic [7:0]             ie_q, ie_d, vec_q, vec_d;
  logic                   commit, ack, pend_valid;
  logic [IW-1:0]          pend_idx;
  assign commit    = t_cycle == 2'd3;
  assign ack       = commit & int_ack;
  // pending is taken from the registers, so an ack sees IF/IE as they were before this edge
  assign pending   = ie_q[NUM_SOURCES-1:0] & if_q;
  assign halt_wake = |pending;
  assign int_req   = ime & halt_wake;
  assign int_vector = vec_q;
  int_priority_enc #(.N(NUM_SOURCES), .IW(IW)) u_enc (
    .req_i  (pending),
    .valid_o(pend_valid),
    .idx_o  (pend_idx)
  );
`ifdef INT_EDGE_DETECT_EN
  logic [NUM_SOURCES-1:0] hist_q;
  // history clears on reset so a source already high at release counts as a fresh edge
  always_ff @(posedge clk) hist_q <= reset ? '0 : irq_src;
  assign set_mask = irq_src & ~hist_q;
`else
  assign set_mask = irq_src;
`endif
  assign clr_mask = NUM_SOURCES'(1) << pend_idx;
  // write, then ack clear, then new requests; a new request always wins
  assign if_wr = (commit & reg_write & reg_sel_if) ? reg_wdata[NUM_SOURCES-1:0] : if_q;
  assign if_d  = ((ack & pend_valid) ? (if_wr & ~clr_mask) : if_wr) | set_mask;
  assign ie_d  = (commit & reg_write & reg_sel_ie) ? reg_wdata : ie_q;
  assign vec_d = ack ? (pend_valid ? vector_of(VECTOR_BASE, VECTOR_STRIDE, 8'(pend_idx)) : 8'h00) : vec_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      if_q  <= '0;
      ie_q  <= '0;
      vec_q <= 8'h00;
    end else begin
      if_q  <= if_d;
      ie_q  <= ie_d;
      vec_q <= vec_d;
    end
  end
  assign reg_rdata = reg_sel_if ? {IF_UNUSED_BITS, if_q} : reg_sel_ie ? ie_q : 8'hFF;
endmodule

// File: tb/tb_cpu_interrupt_ctrl.sv
// tb_cpu_interrupt_ctrl: directed scenarios plus randomized run against a behavioural model.
module tb_cpu_interrupt_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] t_cycle;
  logic [4:0] irq_src;
  logic       reg_sel_if, reg_sel_ie, reg_write;
  logic [7:0] reg_wdata, reg_rdata;
  logic       ime, int_ack, int_req, halt_wake;
  logic [7:0] int_vector;
  int n_checks = 0;
  int n_pass = 0;
  logic [4:0] m_if, m_hist;
  logic [7:0] m_ie, m_vec;
  always #5 clk = ~clk;
  cpu_interrupt_ctrl dut (
    .clk(clk), .reset(reset), .t_cycle(t_cycle), .irq_src(irq_src),
    .reg_sel_if(reg_sel_if), .reg_sel_ie(reg_sel_ie), .reg_write(reg_write),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .ime(ime), .int_ack(int_ack),
    .int_req(int_req), .halt_wake(halt_wake), .int_vector(int_vector)
  );
  // advance one clock; the model computes the next state from the rules, then the edge happens
  task automatic tick();
    logic [4:0] nif, setm, pend, nhist;
    logic [7:0] nie, nvec;
    bit found;
    nif = m_if; nie = m_ie; nvec = m_vec; found = 0;
`ifdef INT_EDGE_DETECT_EN
    setm = irq_src & ~m_hist;
`else
    setm = irq_src;
`endif
    nhist = reset ? 5'd0 : irq_src;
    if (t_cycle == 2'd3) begin
      if (reg_write && reg_sel_if) nif = reg_wdata[4:0];
      if (reg_write && reg_sel_ie) nie = reg_wdata;
      if (int_ack) begin
        pend = m_ie[4:0] & m_if;
        nvec = 8'h00;
        for (int n = 0; n < 5; n++)
          if (!found && pend[n]) begin
            found = 1;
            nif[n] = 1'b0;
            nvec = 8'h40 + 8'(n * 8);
          end
      end
    end
    nif = nif | setm;
    if (reset) begin nif = 0; nie = 0; nvec = 0; end
    @(posedge clk);
    #1;
    m_if = nif; m_ie = nie; m_vec = nvec; m_hist = nhist;
  endtask
  task automatic idle();
    t_cycle = 0; irq_src = 0; reg_sel_if = 0; reg_sel_ie = 0;
    reg_write = 0; reg_wdata = 0; int_ack = 0;
  endtask
  task automatic wr(input bit to_if, input logic [7:0] d);
    t_cycle = 3; reg_write = 1; reg_sel_if = to_if; reg_sel_ie = !to_if; reg_wdata = d;
    tick(); idle();
  endtask
  task automatic ack1();
    t_cycle = 3; int_ack = 1; tick(); idle();
  endtask
  task automatic rd(input bit s_if, input bit s_ie);
    reg_sel_if = s_if; reg_sel_ie = s_ie; #1;
  endtask
  task automatic test_reset();
    reset = 1; ime = 1; t_cycle = 3; irq_src = 5'h1F; reg_write = 1; reg_sel_if = 1;
    reg_sel_ie = 0; reg_wdata = 8'hFF; int_ack = 1;
    tick();
    idle(); tick(); reset = 0; ime = 0;
    rd(0, 0);
    n_checks++; if (reg_rdata !== 8'hFF) $display("FAIL reset_rdata got %h want ff", reg_rdata); else n_pass++;
    n_checks++; if (int_req !== 1'b0) $display("FAIL reset_int_req got %b want 0", int_req); else n_pass++;
    n_checks++; if (halt_wake !== 1'b0) $display("FAIL reset_halt_wake got %b want 0", halt_wake); else n_pass++;
    n_checks++; if (int_vector !== 8'h00) $display("FAIL reset_vector got %h want 00", int_vector); else n_pass++;
    rd(1, 0);
    n_checks++; if (reg_rdata !== 8'hE0) $display("FAIL reset_if got %h want e0", reg_rdata); else n_pass++;
    rd(0, 1);
    n_checks++; if (reg_rdata !== 8'h00) $display("FAIL reset_ie got %h want 00", reg_rdata); else n_pass++;
    idle();
  endtask
  task automatic test_basic();
    wr(0, 8'h05);
    irq_src = 5'h04; tick(); irq_src = 0; tick();
    rd(1, 0);
    n_checks++; if (reg_rdata !== 8'hE4) $display("FAIL basic_if got %h want e4", reg_rdata); else n_pass++;
    n_checks++; if (halt_wake !== 1'b1) $display("FAIL basic_wake got %b want 1", halt_wake); else n_pass++;
    n_checks++; if (int_req !== 1'b0) $display("FAIL basic_req_noime got %b want 0", int_req); else n_pass++;
    ime = 1; #1;
    n_checks++; if (int_req !== 1'b1) $display("FAIL basic_req_ime got %b want 1", int_req); else n_pass++;
    ack1(); rd(1, 0);
    n_checks++; if (int_vector !== 8'h50) $display("FAIL basic_vector got %h want 50", int_vector); else n_pass++;
    n_checks++; if (reg_rdata !== 8'hE0) $display("FAIL basic_if_clr got %h want e0", reg_rdata); else n_pass++;
    idle();
  endtask
  task automatic test_chain();
    logic [7:0] want;
    wr(1, 8'h1F); wr(0, 8'h1F); ime = 1;
    for (int k = 0; k < 5; k++) begin
      ack1();
      want = 8'h40 + 8'(k * 8);
      n_checks++; if (int_vector !== want) $display("FAIL chain_vector%0d got %h want %h", k, int_vector, want); else n_pass++;
    end
    rd(1, 0);
    n_checks++; if (reg_rdata !== 8'hE0) $display("FAIL chain_if got %h want e0", reg_rdata); else n_pass++;
    n_checks++; if (int_req !== 1'b0) $display("FAIL chain_req got %b want 0", int_req); else n_pass++;
    idle();
  endtask
  task automatic test_cancel();
    wr(1, 8'h01); wr(0, 8'h01); wr(0, 8'h00);
    ack1(); rd(1, 0);
    n_checks++; if (int_vector !== 8'h00) $display("FAIL cancel_vector got %h want 00", int_vector); else n_pass++;
    n_checks++; if (reg_rdata !== 8'hE1) $display("FAIL cancel_if got %h want e1", reg_rdata); else n_pass++;
    idle();
    wr(0, 8'h01);
    t_cycle = 3; int_ack = 1; reg_write = 1; reg_sel_ie = 1; reg_wdata = 8'h00; tick(); idle();
    rd(1, 0);
    n_checks++; if (int_vector !== 8'h40) $display("FAIL ack_ie_same_vector got %h want 40", int_vector); else n_pass++;
    n_checks++; if (reg_rdata !== 8'hE0) $display("FAIL ack_ie_same_if got %h want e0", reg_rdata); else n_pass++;
    idle();
  endtask
  task automatic test_collisions();
    t_cycle = 3; reg_write = 1; reg_sel_if = 1; reg_wdata = 8'h00; irq_src = 5'h01; tick(); idle(); tick();
    rd(1, 0);
    n_checks++; if (reg_rdata !== 8'hE1) $display("FAIL write_vs_set got %h want e1", reg_rdata); else n_pass++;
    idle(); wr(0, 8'h01);
    t_cycle = 3; int_ack = 1; irq_src = 5'h01; tick(); idle(); tick();
    rd(1, 0);
    n_checks++; if (reg_rdata !== 8'hE1) $display("FAIL ack_vs_set got %h want e1", reg_rdata); else n_pass++;
    n_checks++; if (int_vector !== 8'h40) $display("FAIL ack_vs_set_vec got %h want 40", int_vector); else n_pass++;
    idle();
  endtask
  task automatic test_ack_timing();
    wr(1, 8'h03); wr(0, 8'h03);
    t_cycle = 1; int_ack = 1; tick(); idle(); rd(1, 0);
    n_checks++; if (reg_rdata !== 8'hE3) $display("FAIL ack_off_t3_if got %h want e3", reg_rdata); else n_pass++;
    n_checks++; if (int_vector !== 8'h40) $display("FAIL ack_off_t3_vec got %h want 40", int_vector); else n_pass++;
    idle(); int_ack = 1;
    for (int c = 0; c < 4; c++) begin t_cycle = 2'(c); tick(); end
    rd(1, 0);
    n_checks++; if (reg_rdata !== 8'hE2) $display("FAIL hold_ack1_if got %h want e2", reg_rdata); else n_pass++;
    for (int c = 0; c < 4; c++) begin t_cycle = 2'(c); tick(); end
    rd(1, 0);
    n_checks++; if (reg_rdata !== 8'hE0) $display("FAIL hold_ack2_if got %h want e0", reg_rdata); else n_pass++;
    n_checks++; if (int_vector !== 8'h48) $display("FAIL hold_ack2_vec got %h want 48", int_vector); else n_pass++;
    idle();
  endtask
  task automatic test_read_mux();
    wr(1, 8'h02); rd(1, 0);
    n_checks++; if (reg_rdata !== 8'hE2) $display("FAIL read_if got %h want e2", reg_rdata); else n_pass++;
    idle(); wr(0, 8'hFF); rd(0, 1);
    n_checks++; if (reg_rdata !== 8'hFF) $display("FAIL read_ie got %h want ff", reg_rdata); else n_pass++;
    wr(0, 8'h5A); rd(0, 1);
    n_checks++; if (reg_rdata !== 8'h5A) $display("FAIL read_ie2 got %h want 5a", reg_rdata); else n_pass++;
    rd(0, 0);
    n_checks++; if (reg_rdata !== 8'hFF) $display("FAIL read_none got %h want ff", reg_rdata); else n_pass++;
    idle(); wr(1, 8'h00);
  endtask
`ifdef INT_EDGE_DETECT_EN
  task automatic test_edge();
    ime = 0; wr(1, 8'h00); wr(0, 8'h08);
    irq_src = 5'h08;
    for (int c = 0; c < 20; c++) tick();
    rd(1, 0);
    n_checks++; if (reg_rdata !== 8'hE8) $display("FAIL edge_once got %h want e8", reg_rdata); else n_pass++;
    t_cycle = 3; int_ack = 1; tick(); t_cycle = 0; int_ack = 0;
    for (int c = 0; c < 5; c++) tick();
    rd(1, 0);
    n_checks++; if (reg_rdata !== 8'hE0) $display("FAIL edge_held_after_ack got %h want e0", reg_rdata); else n_pass++;
    n_checks++; if (int_vector !== 8'h58) $display("FAIL edge_vec got %h want 58", int_vector); else n_pass++;
    reset = 1; tick(); rd(1, 0);
    n_checks++; if (reg_rdata !== 8'hE0) $display("FAIL edge_reset got %h want e0", reg_rdata); else n_pass++;
    reset = 0; tick(); rd(1, 0);
    n_checks++; if (reg_rdata !== 8'hE8) $display("FAIL edge_release got %h want e8", reg_rdata); else n_pass++;
    idle(); tick(); wr(1, 8'h00);
  endtask
`endif
  task automatic test_random();
    logic [7:0] exp_rd;
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      t_cycle = 2'($urandom);
      irq_src = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
      reg_write = ($urandom_range(0, 3) == 0);
      reg_sel_if = ($urandom_range(0, 2) == 0);
      reg_sel_ie = !reg_sel_if && ($urandom_range(0, 2) == 0);
      reg_wdata = 8'($urandom);
      ime = 1'($urandom);
      int_ack = ($urandom_range(0, 2) == 0);
      tick();
      reg_write = 0; int_ack = 0; #1;
      exp_rd = reg_sel_if ? {3'b111, m_if} : reg_sel_ie ? m_ie : 8'hFF;
      n_checks++;
      if (int_vector !== m_vec || halt_wake !== |(m_ie[4:0] & m_if) ||
          int_req !== (ime & |(m_ie[4:0] & m_if)) || reg_rdata !== exp_rd) begin
        if (bad < 10)
          $display("FAIL random%0d got vec=%h wake=%b req=%b rd=%h want vec=%h wake=%b req=%b rd=%h",
                   i, int_vector, halt_wake, int_req, reg_rdata, m_vec, |(m_ie[4:0] & m_if),
                   ime & |(m_ie[4:0] & m_if), exp_rd);
        bad++;
      end else n_pass++;
    end
    reset = 0; idle();
  endtask
  initial begin
    m_if = 0; m_ie = 0; m_vec = 0; m_hist = 0;
    reset = 1; ime = 0; idle();
    test_reset();
    test_basic();
    test_chain();
    test_cancel();
    test_collisions();
    test_ack_timing();
    test_read_mux();
`ifdef INT_EDGE_DETECT_EN
    test_edge();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
